// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-port round-robin arbiter.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot vector with bit idx set; all zeros when idx is outside 0..n-1.
  function automatic logic [31:0] onehot(input int idx, input int n);
    if (idx >= 0 && idx < n) return 32'd1 << idx;
    return 32'd0;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the FIFO, the arbiter and its consumers (rclk domain).
interface fifo_rd_arbiter_if
  import fifo_rd_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
) ();
  localparam int ID_W = $clog2(N_REQ);

  // Handshake: req is a level held by a consumer while it wants data, with no
  // ready back to it; r_en is a read strobe that pops fifo_rdata when !empty;
  // rd_valid is a single-cycle strobe with no backpressure, qualifying rd_data/rd_id.
  logic [N_REQ-1:0]      req;
  logic                  empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  r_en;
  logic [N_REQ-1:0]      rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ID_W-1:0]       rd_id;
  logic                  busy;
  arb_state_t            dbg_state;

  modport master (
    input  req, empty, fifo_rdata,
    output r_en, rd_valid, rd_data, rd_id, busy, dbg_state
  );

  modport slave (
    output req, empty, fifo_rdata,
    input  r_en, rd_valid, rd_data, rd_id, busy, dbg_state
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1, with wrap.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_REQ-1:0] dbl;
  assign dbl = {req, req};

  // Scan from farthest to nearest so the nearest hit after last wins; the
  // previous owner (offset N_REQ) is the lowest-priority candidate.
  always_comb begin
    int p;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      p = int'(last) + k;
      if (dbl[p]) begin
        found = 1'b1;
        idx   = ID_W'((p >= N_REQ) ? (p - N_REQ) : p);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin sharing of the async FIFO read port among N_REQ consumers.
// Define FIFO_RD_ARB_BURST_EN to allow up to MAX_BURST reads per grant.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               rclk,
  input  logic               rrst_n,
  fifo_rd_arbiter_if.master  bus
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t            state;
  logic [ID_W-1:0]       owner;
  logic [ID_W-1:0]       last;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic                  r_en_c;
  logic [N_REQ-1:0]      rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ID_W-1:0]       rd_id_q;

`ifdef FIFO_RD_ARB_BURST_EN
  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BCNT_W-1:0] bcnt;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Reads only in GRANT while the owner still asks and a word is present.
  assign r_en_c = rrst_n && (state == GRANT) && bus.req[owner] && !bus.empty;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state      <= IDLE;
      last       <= ID_W'(N_REQ - 1);
      owner      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
`ifdef FIFO_RD_ARB_BURST_EN
      bcnt       <= '0;
`endif
    end else begin
      rd_valid_q <= '0;
      if (r_en_c) begin
        rd_data_q  <= bus.fifo_rdata;
        rd_valid_q <= N_REQ'(onehot(int'(owner), N_REQ));
        rd_id_q    <= owner;
      end
      case (state)
        IDLE: begin
          if (pick_found && !bus.empty) begin
            owner <= pick_idx;
            state <= GRANT;
`ifdef FIFO_RD_ARB_BURST_EN
            bcnt  <= '0;
`endif
          end
        end
        GRANT: begin
          if (!r_en_c) begin
            state <= IDLE;
            last  <= owner;
`ifdef FIFO_RD_ARB_BURST_EN
          end else if (bcnt == BCNT_W'(MAX_BURST - 1)) begin
            state <= IDLE;
            last  <= owner;
          end else begin
            bcnt  <= bcnt + BCNT_W'(1);
`else
          end else begin
            state <= IDLE;
            last  <= owner;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r_en      = r_en_c;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_id     = rd_id_q;
  assign bus.busy      = (state == GRANT);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a FIFO model and an expected-word queue.
module tb_fifo_rd_arbiter;
  import fifo_rd_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
`ifdef FIFO_RD_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic rclk = 1'b0;
  logic rrst_n;
  always #5 rclk = ~rclk;

  fifo_rd_arbiter_if #(.N_REQ(N), .DATA_WIDTH(W)) bus ();

  fifo_rd_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .MAX_BURST(4)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0]   fifo_q[$];
  logic [W+1:0]   exp_q[$];
  logic [1:0]     t3_ids[8];
  logic [1:0]     t4_ids[10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.empty      = (fifo_q.size() == 0);
    bus.fifo_rdata = bus.empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic exp_word(input logic [1:0] id, input logic [W-1:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic wait_drain(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge rclk);
      #1;
      cnt++;
      if (exp_q.size() == 0) break;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_cycles"}, cnt, cycles);
  endtask

  // FIFO model: pop on each edge with r_en; empty/rdata settle after the edge.
  always begin
    @(posedge rclk);
    if (bus.r_en === 1'b1) begin
      vectors++;
      assert (fifo_q.size() > 0) else begin
        miscompares++;
        $error("FAIL underflow: observed r_en=1 with size %0d expected size>0", fifo_q.size());
      end
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    #1 refresh();
  end

  // Scoreboard: every rd_valid strobe must match the head of exp_q.
  always @(negedge rclk) begin
    logic [W+1:0] e;
    logic [3:0]   oh;
    if (bus.rd_valid !== 4'b0000) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_strobe: observed rd_valid %0b expected none", bus.rd_valid);
      end
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e[W+1:W];
        chk("rd_valid", bus.rd_valid, oh);
        chk("rd_id", bus.rd_id, e[W+1:W]);
        chk("rd_data", bus.rd_data, e[W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if (BURST) begin
      t3_ids = '{0, 0, 0, 0, 1, 1, 1, 1};
      t4_ids = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    end else begin
      t3_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
      t4_ids = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    end

    // 1: reset held with every consumer requesting and data present
    rrst_n  = 1'b0;
    bus.req = 4'hF;
    refresh();
    push(8'h11);
    repeat (3) begin
      @(negedge rclk);
      #1;
      chk("rst_r_en", bus.r_en, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_busy", bus.busy, 0);
    end
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_id", bus.rd_id, 0);
    chk("rst_state", bus.dbg_state, IDLE);
    rrst_n = 1'b1;
    exp_word(2'd0, 8'h11);
    wait_drain("t1", 2);
    bus.req = 4'h0;
    idle(2);

    // 2: single requester, two words
    @(negedge rclk);
    bus.req = 4'b0100;
    push(8'hA5);
    push(8'h5B);
    exp_word(2'd2, 8'hA5);
    exp_word(2'd2, 8'h5B);
    wait_drain("t2", BURST ? 3 : 4);
    bus.req = 4'h0;
    idle(2);

    // 3: all requesting, fresh rotation from consumer 0
    @(negedge rclk);
    rrst_n = 1'b0;
    @(negedge rclk);
    rrst_n  = 1'b1;
    bus.req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      push(8'h30 + 8'(i));
      exp_word(t3_ids[i], 8'h30 + 8'(i));
    end
    wait_drain("t3", BURST ? 10 : 16);
    bus.req = 4'h0;
    idle(2);

    // 4: two requesters, ten words
    @(negedge rclk);
    bus.req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      push(8'h40 + 8'(i));
      exp_word(t4_ids[i], 8'h40 + 8'(i));
    end
    wait_drain("t4", BURST ? 13 : 20);
    bus.req = 4'h0;
    idle(2);

    // 5: FIFO runs dry mid-grant, then a single refill
    @(negedge rclk);
    bus.req = 4'b0010;
    push(8'h50);
    push(8'h51);
    exp_word(2'd1, 8'h50);
    exp_word(2'd1, 8'h51);
    wait_drain("t5", BURST ? 3 : 4);
    @(negedge rclk);
    #1;
    chk("t5_busy_after_empty", bus.busy, 0);
    chk("t5_state_after_empty", bus.dbg_state, IDLE);
    chk("t5_r_en_after_empty", bus.r_en, 0);
    push(8'h52);
    exp_word(2'd1, 8'h52);
    wait_drain("t5_refill", 2);
    bus.req = 4'h0;
    idle(2);

    // 6: owner drops its request while granted
    @(negedge rclk);
    bus.req = 4'b0011;
    push(8'h60);
    push(8'h61);
    @(negedge rclk);
    #1;
    chk("t6_busy", bus.busy, 1);
    chk("t6_state", bus.dbg_state, GRANT);
    bus.req = 4'b0010;
    #1;
    chk("t6_drop_r_en", bus.r_en, 0);
    exp_word(2'd1, 8'h60);
    exp_word(2'd1, 8'h61);
    wait_drain("t6", BURST ? 4 : 5);
    bus.req = 4'h0;
    idle(2);

    // 6b: reset lands on a read cycle
    @(negedge rclk);
    bus.req = 4'b0001;
    push(8'hEE);
    @(negedge rclk);
    #1;
    chk("t7_busy", bus.busy, 1);
    chk("t7_r_en", bus.r_en, 1);
    rrst_n = 1'b0;
    #1;
    chk("t7_r_en_in_reset", bus.r_en, 0);
    bus.req = 4'h0;
    @(negedge rclk);
    #1;
    chk("t7_rd_valid", bus.rd_valid, 0);
    chk("t7_rd_data", bus.rd_data, 0);
    chk("t7_busy_after", bus.busy, 0);
    rrst_n = 1'b1;
    idle(2);
    chk("final_exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
